// File: rtl/frog_pkg.sv
// Shared types and default game constants for the frog rule controller.
// Enum, restart key code and the default frame/lives budgets.
package frog_pkg;

  typedef enum logic [2:0] {
    PLAY,
    DYING,
    HOME,
    GAME_OVER,
    WIN
  } state_e;

  localparam logic [15:0] KEY_ENTER = 16'h0028;

  localparam int DEF_LIVES_INIT   = 3;
  localparam int DEF_DEATH_FRAMES = 60;
  localparam int DEF_GRACE_FRAMES = 30;
  localparam int DEF_TIME_LIMIT   = 1800;
  localparam int DEF_HOME_Y       = 221;
  localparam int DEF_X_MAX        = 620;

endpackage

// File: rtl/frog_life_ctrl_if.sv
// Bundle between the rule controller and the frog/HUD side.
// master = controller, slave = movement block and HUD.
interface frog_life_ctrl_if;

  logic [9:0]  FrogX;
  logic [9:0]  FrogY;
  logic        hit_car;
  logic        in_water;
  logic [15:0] keycode;
  logic        frogreset;
  logic [3:0]  lives;
  logic        stage1x;
  logic        stage2x;
  logic [10:0] time_left;
  logic        game_over;
  logic        win;

  modport master (
    input  FrogX, FrogY, hit_car, in_water, keycode,
    output frogreset, lives, stage1x, stage2x,
    output time_left, game_over, win
  );

  modport slave (
    output FrogX, FrogY, hit_car, in_water, keycode,
    input  frogreset, lives, stage1x, stage2x,
    input  time_left, game_over, win
  );

endinterface

// File: rtl/frame_countdown.sv
// Loadable down-counter that stops at zero.
// Load wins over enable; zero flag reflects the stored count.
module frame_countdown #(
  parameter int           W       = 11,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // load, else count down while enabled, holding at zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/frog_life_ctrl.sv
// Per-frame game rules: death, respawn, stage progress, game over.
// Every output comes straight from a register.
module frog_life_ctrl
  import frog_pkg::*;
#(
  parameter int LIVES_INIT   = DEF_LIVES_INIT,
  parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
  parameter int GRACE_FRAMES = DEF_GRACE_FRAMES,
  parameter int TIME_LIMIT   = DEF_TIME_LIMIT,
  parameter int HOME_Y       = DEF_HOME_Y,
  parameter int X_MAX        = DEF_X_MAX
) (
  input logic             frame_clk,
  input logic             Reset_n,
  frog_life_ctrl_if.master bus
);

  localparam logic [7:0]  GRACE = 8'(GRACE_FRAMES);
  localparam logic [3:0]  LIVES = 4'(LIVES_INIT);
  localparam logic [10:0] TLIM  = 11'(TIME_LIMIT);
  localparam logic [10:0] HOLD  = 11'(DEATH_FRAMES - 1);

  state_e      state_q;
  logic [3:0]  lives_q;
  logic [3:0]  lives_d;
  logic        s1_q;
  logic        s2_q;
  logic        frst_q;
  logic        go_q;
  logic        win_q;
  logic [7:0]  grace_q;

  logic        in_play;
  logic        in_hold;
  logic        in_end;
  logic        hazard;
  logic        die;
  logic        home;
  logic        restart;
  logic        respawn;
  logic        t_zero;
  logic        h_zero;
  logic [10:0] tl;
  logic [10:0] unused_hold_cnt;

  assign in_play = (state_q == PLAY);
  assign in_hold = (state_q == DYING) || (state_q == HOME);
  assign in_end  = (state_q == GAME_OVER) || (state_q == WIN);

  assign hazard = bus.hit_car | bus.in_water
                | (bus.FrogX > 10'(X_MAX));
  assign die    = in_play
                & (((grace_q == '0) & hazard) | t_zero);
  assign home   = in_play & ~die
                & (bus.FrogY <= 10'(HOME_Y));
  assign restart = in_end & (bus.keycode == KEY_ENTER);
  assign respawn = in_hold & h_zero
                 & (((state_q == DYING) & (lives_q != '0))
                 | ((state_q == HOME) & s1_q));
  assign lives_d = (lives_q == '0) ? '0 : lives_q - 4'd1;

  frame_countdown #(
    .W       (11),
    .RST_VAL ('0)
  ) u_hold (
    .clk_i   (frame_clk),
    .rst_ni  (Reset_n),
    .load_i  (die | home),
    .value_i (HOLD),
    .en_i    (in_hold),
    .cnt_o   (unused_hold_cnt),
    .zero_o  (h_zero)
  );

  frame_countdown #(
    .W       (11),
    .RST_VAL (TLIM)
  ) u_time (
    .clk_i   (frame_clk),
    .rst_ni  (Reset_n),
    .load_i  (respawn | restart),
    .value_i (TLIM),
    .en_i    (in_play),
    .cnt_o   (tl),
    .zero_o  (t_zero)
  );

  // rule FSM with its registered status outputs and grace counter
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= PLAY;
      lives_q <= LIVES;
      s1_q    <= 1'b1;
      s2_q    <= 1'b0;
      frst_q  <= 1'b0;
      go_q    <= 1'b0;
      win_q   <= 1'b0;
      grace_q <= '0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (grace_q != '0) grace_q <= grace_q - 8'd1;
          if (die) begin
            state_q <= DYING;
            lives_q <= lives_d;
            frst_q  <= 1'b1;
          end else if (home) begin
            state_q <= HOME;
            frst_q  <= 1'b1;
          end
        end
        DYING: begin
          if (h_zero) begin
            if (lives_q == '0) begin
              state_q <= GAME_OVER;
              go_q    <= 1'b1;
            end else begin
              state_q <= PLAY;
              frst_q  <= 1'b0;
              grace_q <= GRACE;
            end
          end
        end
        HOME: begin
          if (h_zero) begin
            if (s1_q) begin
              s1_q    <= 1'b0;
              s2_q    <= 1'b1;
              state_q <= PLAY;
              frst_q  <= 1'b0;
              grace_q <= GRACE;
            end else begin
              state_q <= WIN;
              win_q   <= 1'b1;
            end
          end
        end
        GAME_OVER, WIN: begin
          if (restart) begin
            state_q <= PLAY;
            lives_q <= LIVES;
            s1_q    <= 1'b1;
            s2_q    <= 1'b0;
            frst_q  <= 1'b0;
            go_q    <= 1'b0;
            win_q   <= 1'b0;
            grace_q <= '0;
          end
        end
        default: state_q <= PLAY;
      endcase
    end
  end

  assign bus.frogreset = frst_q;
  assign bus.lives     = lives_q;
  assign bus.stage1x   = s1_q;
  assign bus.stage2x   = s2_q;
  assign bus.time_left = tl;
  assign bus.game_over = go_q;
  assign bus.win       = win_q;

endmodule
